// File: rtl/bip_dump_sequencer_pkg.sv
// Shared types and constants for the post-halt UART dump sequencer.
// Frame layout: word 0 is the accumulator, word 1 the PC, then the data-memory cells.
package bip_dump_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StSendLo,
        StWaitLo,
        StSendHi,
        StWaitHi,
        StFinish
    } state_e;

    localparam int unsigned W_ACC  = 0;
    localparam int unsigned W_PC   = 1;
    localparam int unsigned W_MEM0 = 2;

    localparam int unsigned CELDAS_DEFAULT = 10;
    localparam int unsigned FRAME_WORDS    = CELDAS_DEFAULT + W_MEM0;

    function automatic int unsigned frame_words(input int unsigned celdas);
        return celdas + W_MEM0;
    endfunction

endpackage

// File: rtl/bip_dump_sequencer_if.sv
// Byte-level handshake between the dump sequencer and uart_tx.
interface bip_dump_sequencer_if #(
    parameter int unsigned DBIT = 8
);
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            tx_done;

    modport master (output tx_start, output tx_data, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/bip_dump_word_mux.sv
// Picks the frame word for index w: accumulator snapshot, PC snapshot or RAM read data.
module bip_dump_word_mux
    import bip_dump_sequencer_pkg::*;
#(
    parameter int unsigned NBITS_D = 16,
    parameter int unsigned IDXW    = 4
) (
    input  logic [IDXW-1:0]    i_sel,
    input  logic [NBITS_D-1:0] i_acc,
    input  logic [NBITS_D-1:0] i_pc,
    input  logic [NBITS_D-1:0] i_mem_data,
    output logic [NBITS_D-1:0] o_word
);

    always_comb begin
        o_word = i_mem_data;
        if (i_sel == IDXW'(W_ACC)) begin
            o_word = i_acc;
        end else if (i_sel == IDXW'(W_PC)) begin
            o_word = i_pc;
        end
    end

endmodule

// File: rtl/bip_dump_sequencer.sv
// Once the BIP halts, streams acc, PC and data memory to uart_tx, low byte first,
// one outstanding byte at a time.
module bip_dump_sequencer
    import bip_dump_sequencer_pkg::*;
#(
    parameter int unsigned NBITS_D = 16,
    parameter int unsigned NBITS_O = 11,
    parameter int unsigned DBIT    = 8,
    parameter int unsigned CELDAS  = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_halt,
    input  logic [NBITS_D-1:0]   i_acc,
    input  logic [NBITS_O-1:0]   i_pc,
    output logic [NBITS_O-1:0]   o_mem_addr,
    input  logic [NBITS_D-1:0]   i_mem_data,
    bip_dump_sequencer_if.master io_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned NWORDS = frame_words(CELDAS);
    localparam int unsigned IDXW   = $clog2(NWORDS);
    localparam logic [IDXW-1:0] LAST_W = IDXW'(NWORDS - 1);
    localparam logic [IDXW-1:0] MEM0_W = IDXW'(W_MEM0);

    generate
        if (NBITS_D != 2 * DBIT) begin : g_width_check
            $error("bip_dump_sequencer: NBITS_D must equal 2*DBIT");
        end
    endgenerate

    state_e               r_state;
    state_e               w_state_d;
    logic                 r_halt_q;
    logic [IDXW-1:0]      r_w;
    logic [NBITS_D-1:0]   r_acc_snap;
    logic [NBITS_D-1:0]   r_pc_snap;
    logic [NBITS_D-1:0]   r_word;
    logic [DBIT-1:0]      r_tx_data;
    logic [NBITS_O-1:0]   r_mem_addr;
    logic [NBITS_O-1:0]   w_mem_addr;
    logic [NBITS_D-1:0]   w_word;
    logic                 w_edge;

    assign w_edge = i_halt & ~r_halt_q;

    bip_dump_word_mux #(
        .NBITS_D (NBITS_D),
        .IDXW    (IDXW)
    ) u_word_mux (
        .i_sel      (r_w),
        .i_acc      (r_acc_snap),
        .i_pc       (r_pc_snap),
        .i_mem_data (i_mem_data),
        .o_word     (w_word)
    );

    // Address goes out combinationally in FETCH so RAM data lands in CAPTURE.
    always_comb begin
        w_mem_addr = r_mem_addr;
        if (r_state == StFetch && r_w >= MEM0_W) begin
            w_mem_addr = NBITS_O'(r_w - MEM0_W);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_edge) w_state_d = StFetch;
            StFetch:   w_state_d = StCapture;
            StCapture: w_state_d = StSendLo;
            StSendLo:  w_state_d = StWaitLo;
            StWaitLo:  if (io_tx.tx_done) w_state_d = StSendHi;
            StSendHi:  w_state_d = StWaitHi;
            StWaitHi: begin
                if (io_tx.tx_done) begin
                    w_state_d = (r_w == LAST_W) ? StFinish : StFetch;
                end
            end
            StFinish:  w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_halt_q   <= 1'b0;
            r_w        <= '0;
            r_acc_snap <= '0;
            r_pc_snap  <= '0;
            r_word     <= '0;
            r_tx_data  <= '0;
            r_mem_addr <= '0;
        end else begin
            r_halt_q <= i_halt;
            if (r_state == StIdle && w_edge) begin
                r_acc_snap <= i_acc;
                r_pc_snap  <= {{(NBITS_D - NBITS_O){1'b0}}, i_pc};
            end
            if (r_state == StFetch) begin
                r_mem_addr <= w_mem_addr;
            end
            if (r_state == StCapture) begin
                r_word    <= w_word;
                r_tx_data <= w_word[DBIT-1:0];
            end
            if (r_state == StWaitLo && io_tx.tx_done) begin
                r_tx_data <= r_word[NBITS_D-1:DBIT];
            end
            if (r_state == StWaitHi && io_tx.tx_done && r_w != LAST_W) begin
                r_w <= r_w + 1'b1;
            end
            if (r_state == StFinish) begin
                r_w <= '0;
            end
        end
    end

    always_comb begin
        io_tx.tx_start = (r_state == StSendLo) || (r_state == StSendHi);
        io_tx.tx_data  = r_tx_data;
        o_mem_addr     = w_mem_addr;
        o_busy         = (r_state != StIdle);
        o_done         = (r_state == StFinish);
    end

endmodule

// File: tb/tb_bip_dump_sequencer.sv
// Directed frames with randomized data and tx_done latency, checked against a
// byte-stream reference built from the frame layout rules.
module tb_bip_dump_sequencer;

    localparam int unsigned NBITS_D = 16;
    localparam int unsigned NBITS_O = 11;
    localparam int unsigned DBIT    = 8;
    localparam int unsigned CELDAS  = 10;
    localparam int          NBYTES  = 2 * (CELDAS + 2);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               halt = 1'b0;
    logic [NBITS_D-1:0] acc = '0;
    logic [NBITS_O-1:0] pc = '0;
    logic [NBITS_O-1:0] mem_addr;
    logic [NBITS_D-1:0] mem_data;
    logic               busy;
    logic               done;
    logic               resp_done = 1'b0;
    logic               spur_done = 1'b0;

    bip_dump_sequencer_if #(.DBIT(DBIT)) tx_if ();
    assign tx_if.tx_done = resp_done | spur_done;

    bip_dump_sequencer #(
        .NBITS_D (NBITS_D),
        .NBITS_O (NBITS_O),
        .DBIT    (DBIT),
        .CELDAS  (CELDAS)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_halt     (halt),
        .i_acc      (acc),
        .i_pc       (pc),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .io_tx      (tx_if),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data RAM with one cycle of read latency.
    logic [NBITS_D-1:0] mem [CELDAS];
    always @(posedge clk) begin
        if (mem_addr < NBITS_O'(CELDAS)) mem_data <= mem[mem_addr[3:0]];
        else                             mem_data <= 16'hDEAD;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         frame_base = 0;
    int         edge_cyc   = 0;
    int         last_done  = 0;
    int         maxdelay   = 20;
    bit         waiting    = 1'b0;
    bit         rst_abort  = 1'b0;

    // uart_tx stand-in: records bytes, answers each start with a delayed done pulse.
    initial begin
        int         cnt;
        int         pos;
        logic [7:0] held;
        cnt  = 0;
        held = '0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (waiting) begin
                check("overlap_start", 32'(tx_if.tx_start), 32'd0);
                if (!rst_abort) check("data_stable", 32'(tx_if.tx_data), 32'(held));
                cnt--;
                if (cnt == 0) begin
                    resp_done = 1'b1;
                    waiting   = 1'b0;
                    last_done = cyc;
                end
            end else if (tx_if.tx_start === 1'b1) begin
                pos = got.size() - frame_base;
                if (pos == 0)          check("gap_first", 32'(cyc - edge_cyc), 32'd3);
                else if (pos % 2 == 1) check("gap_hi", 32'(cyc - last_done), 32'd1);
                else                   check("gap_lo", 32'(cyc - last_done), 32'd3);
                got.push_back(tx_if.tx_data);
                held    = tx_if.tx_data;
                waiting = 1'b1;
                cnt     = int'($urandom_range(maxdelay, 1));
            end
        end
    end

    task automatic fill_expected(input logic [15:0] a, input logic [10:0] p);
        logic [15:0] word;
        exp_q.delete();
        for (int w = 0; w < CELDAS + 2; w++) begin
            if (w == 0)      word = a;
            else if (w == 1) word = {5'b0, p};
            else             word = mem[w-2];
            exp_q.push_back(word[7:0]);
            exp_q.push_back(word[15:8]);
        end
    endtask

    task automatic wait_resp_idle();
        int n;
        n = 0;
        while (waiting && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("resp_idle", 32'(waiting), 32'd0);
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < CELDAS; k++) mem[k] = 16'($urandom);
    endtask

    // Drop halt for one cycle, raise it, and check one complete frame.
    task automatic run_frame(input logic [15:0] a, input logic [10:0] p, input int md,
                             input bit perturb);
        int   budget;
        int   ndone;
        int   n;
        int   addr_q[$];
        maxdelay = md;
        wait_resp_idle();
        @(negedge clk);
        halt = 1'b0;
        acc  = a;
        pc   = p;
        @(negedge clk);
        halt       = 1'b1;
        frame_base = got.size();
        edge_cyc   = cyc;
        fill_expected(a, p);
        @(negedge clk);
        check("busy_fetch", 32'(busy), 32'd1);
        if (perturb) begin
            acc       = 16'hFFFF;
            pc        = ~p;
            spur_done = 1'b1;
        end
        budget = NBYTES * (md + 4) + 40;
        ndone  = 0;
        n      = 0;
        while (n < budget && ndone == 0) begin
            @(negedge clk);
            spur_done = 1'b0;
            n++;
            if (done === 1'b1) ndone++;
            if (addr_q.size() == 0 || addr_q[addr_q.size()-1] != int'(mem_addr))
                addr_q.push_back(int'(mem_addr));
        end
        check("done_seen", 32'(ndone), 32'd1);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("byte_count", 32'(got.size() - frame_base), 32'(NBYTES));
        for (int i = 0; i < NBYTES && frame_base + i < got.size(); i++)
            check($sformatf("byte%0d", i), 32'(got[frame_base+i]), 32'(exp_q[i]));
        while (addr_q.size() > 0 && addr_q[0] != 0) void'(addr_q.pop_front());
        check("addr_count", 32'(addr_q.size()), 32'(CELDAS));
        for (int i = 0; i < CELDAS && i < addr_q.size(); i++)
            check($sformatf("addr%0d", i), 32'(addr_q[i]), 32'(i));
    endtask

    initial begin
        int n0;
        int n;
        logic [15:0] a;
        logic [10:0] p;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_if.tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Spurious done while idle must not start anything.
        @(negedge clk);
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        check("idle_spur_bytes", 32'(got.size()), 32'd0);
        check("idle_spur_busy", 32'(busy), 32'd0);

        for (int k = 0; k < CELDAS; k++) mem[k] = 16'hA000 + 16'(k);
        run_frame(16'h1234, 11'h07F, 20, 1'b1);

        // Halt stays high: no retrigger.
        n0 = got.size();
        repeat (800) @(negedge clk);
        check("hold_no_retrigger", 32'(got.size() - n0), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);

        run_frame(16'h1234, 11'h07F, 20, 1'b0);

        randomize_mem();
        run_frame(16'($urandom), 11'($urandom), 500, 1'b1);
        randomize_mem();
        run_frame(16'($urandom), 11'($urandom), 20, 1'b0);

        // Reset after the fifth byte's start.
        maxdelay = 20;
        randomize_mem();
        a = 16'($urandom);
        p = 11'($urandom);
        wait_resp_idle();
        @(negedge clk);
        halt = 1'b0;
        acc  = a;
        pc   = p;
        @(negedge clk);
        halt       = 1'b1;
        frame_base = got.size();
        edge_cyc   = cyc;
        fill_expected(a, p);
        n = 0;
        while (got.size() - frame_base < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte5", 32'(got.size() - frame_base), 32'd5);
        rst_abort = 1'b1;
        rst       = 1'b1;
        halt      = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_start", 32'(tx_if.tx_start), 32'd0);
        check("mid_rst_tx_data", 32'(tx_if.tx_data), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("no_start_after_rst", 32'(got.size() - frame_base), 32'd5);
        for (int i = 0; i < 5 && frame_base + i < got.size(); i++)
            check($sformatf("rst_byte%0d", i), 32'(got[frame_base+i]), 32'(exp_q[i]));
        wait_resp_idle();
        rst_abort = 1'b0;

        randomize_mem();
        run_frame(16'($urandom), 11'($urandom), 20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
